// File: rtl/temp_frame_if.sv
// temp_frame_if: byte input, FSM clear and verdict outputs of the temperature frame decoder.
interface temp_frame_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        clr;
  logic [7:0]  verdict;
  logic        verdict_valid;
  logic [15:0] temp_tenths;
  logic        frame_err;
  logic        busy;
  modport master (output rx_data, rx_valid, clr,
                  input  verdict, verdict_valid, temp_tenths, frame_err, busy);
  modport slave  (input  rx_data, rx_valid, clr,
                  output verdict, verdict_valid, temp_tenths, frame_err, busy);
endinterface

// File: rtl/temp_frame_decoder.sv
// temp_frame_decoder: parses HDR,T_HI,T_LO[,CHK] byte frames into a held verdict code (1 fever, 2 pass).
// Define TEMP_CHECKSUM_EN for the 4-byte frame with an additive checksum byte.
module temp_frame_decoder #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TIMEOUT_MS   = 10,
  parameter logic [15:0] FEVER_TENTHS = 16'd375,
  parameter logic [15:0] MIN_TENTHS   = 16'd300,
  parameter logic [15:0] MAX_TENTHS   = 16'd450,
  parameter logic [7:0]  HDR_BYTE     = 8'hAA
) (
  input logic        clk,
  input logic        reset,
  temp_frame_if.slave bus
);
  localparam int unsigned TC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int CW = $clog2(TC + 1);
`ifdef TEMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, T_HI, T_LO, CHK, EVAL} state_t;
`else
  typedef enum logic [2:0] {IDLE, T_HI, T_LO, EVAL} state_t;
`endif
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d, lo_q, lo_d;
  logic [7:0]  verdict_q, verdict_d;
  logic        vv_q, vv_d, err_q, err_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] reading;
  logic        wait_st, timeout, sum_ok, in_range, eval_ok, eval_bad;
`ifdef TEMP_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif
  always_comb begin
    reading   = {hi_q, lo_q};
    wait_st   = state_q != IDLE && state_q != EVAL;
    timeout   = wait_st && !bus.rx_valid && cnt_q == CW'(TC - 1);
    cnt_d     = (wait_st && !bus.rx_valid && !timeout) ? cnt_q + 1'b1 : '0;
    hi_d      = (state_q == T_HI && bus.rx_valid) ? bus.rx_data : hi_q;
    lo_d      = (state_q == T_LO && bus.rx_valid) ? bus.rx_data : lo_q;
`ifdef TEMP_CHECKSUM_EN
    chk_d     = (state_q == CHK && bus.rx_valid) ? bus.rx_data : chk_q;
    sum_ok    = chk_q == 8'(HDR_BYTE + hi_q + lo_q);
`else
    sum_ok    = 1'b1;
`endif
    in_range  = reading >= MIN_TENTHS && reading <= MAX_TENTHS;
    eval_ok   = state_q == EVAL && sum_ok && in_range;
    eval_bad  = state_q == EVAL && !(sum_ok && in_range);
    // A verdict loaded in EVAL takes priority over a coincident clr
    verdict_d = eval_ok ? ((reading >= FEVER_TENTHS) ? 8'd1 : 8'd2) : bus.clr ? 8'd0 : verdict_q;
    temp_d    = eval_ok ? reading : temp_q;
    vv_d      = eval_ok;
    err_d     = eval_bad || timeout;
    state_d   = state_q;
    case (state_q)
      IDLE: state_d = (bus.rx_valid && bus.rx_data == HDR_BYTE) ? T_HI : IDLE;
      T_HI: state_d = bus.rx_valid ? T_LO : T_HI;
`ifdef TEMP_CHECKSUM_EN
      T_LO: state_d = bus.rx_valid ? CHK : T_LO;
      CHK:  state_d = bus.rx_valid ? EVAL : CHK;
`else
      T_LO: state_d = bus.rx_valid ? EVAL : T_LO;
`endif
      EVAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      verdict_q <= '0;
      vv_q      <= 1'b0;
      err_q     <= 1'b0;
      temp_q    <= '0;
`ifdef TEMP_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      verdict_q <= verdict_d;
      vv_q      <= vv_d;
      err_q     <= err_d;
      temp_q    <= temp_d;
`ifdef TEMP_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end
  assign bus.verdict       = verdict_q;
  assign bus.verdict_valid = vv_q;
  assign bus.temp_tenths   = temp_q;
  assign bus.frame_err     = err_q;
  assign bus.busy          = state_q != IDLE;
endmodule

// File: tb/tb_temp_frame_decoder.sv
// tb_temp_frame_decoder: directed frames; expected verdict/error events queued and checked by a monitor.
module tb_temp_frame_decoder;
  localparam int TC = 1000;
  typedef struct {
    bit          err;
    logic [7:0]  v;
    logic [15:0] t;
    int          at;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t e;
  temp_frame_if bus ();
  temp_frame_decoder #(.CLK_HZ(100_000), .TIMEOUT_MS(10)) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && (bus.verdict_valid || bus.frame_err)) begin
      check("vv_fe_exclusive", 32'(bus.verdict_valid & bus.frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got vv=%0b fe=%0b at cycle %0d expected none",
                 bus.verdict_valid, bus.frame_err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(bus.frame_err), 32'(e.err));
        check("event_cycle", 32'(cyc), 32'(e.at));
        if (!e.err) begin
          check("event_verdict", 32'(bus.verdict), 32'(e.v));
          check("event_temp", 32'(bus.temp_tenths), 32'(e.t));
        end
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit err,
                            input logic [7:0] v, input logic [15:0] t,
                            input bit clr_eval = 1'b0, input bit bad_chk = 1'b0);
    logic [7:0] last;
    send_byte(8'hAA);
    send_byte(hi);
`ifdef TEMP_CHECKSUM_EN
    send_byte(lo);
    last = bad_chk ? 8'h00 : 8'(8'hAA + hi + lo);
`else
    last = lo;
`endif
    @(negedge clk);
    bus.rx_data  = last;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    exp_q.push_back('{err, v, t, cyc + 1});
    if (clr_eval) bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_held(input string name, input logic [7:0] v, input logic [15:0] t);
    check({name, "_verdict"}, 32'(bus.verdict), 32'(v));
    check({name, "_temp"}, 32'(bus.temp_tenths), 32'(t));
  endtask
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_verdict", 32'(bus.verdict), 32'd0);
    check("rst_vv", 32'(bus.verdict_valid), 32'd0);
    check("rst_temp", 32'(bus.temp_tenths), 32'd0);
    check("rst_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    send_frame(8'h01, 8'h5E, 1'b0, 8'd2, 16'd350);
    expect_held("pass350", 8'd2, 16'd350);
    send_frame(8'h01, 8'h7C, 1'b0, 8'd1, 16'd380);
    @(negedge clk) bus.clr = 1'b1;
    @(negedge clk) bus.clr = 1'b0;
    expect_held("clr", 8'd0, 16'd380);
    send_frame(8'h01, 8'h5E, 1'b0, 8'd2, 16'd350);
    send_frame(8'h01, 8'hF4, 1'b1, 8'd0, 16'd0);
    expect_held("range500", 8'd2, 16'd350);
`ifdef TEMP_CHECKSUM_EN
    send_frame(8'h01, 8'h5E, 1'b1, 8'd0, 16'd0, 1'b0, 1'b1);
    expect_held("badchk", 8'd2, 16'd350);
`endif
    send_frame(8'h01, 8'h2B, 1'b1, 8'd0, 16'd0);
    expect_held("range299", 8'd2, 16'd350);
    send_frame(8'h01, 8'h2C, 1'b0, 8'd2, 16'd300);
    send_frame(8'h01, 8'h76, 1'b0, 8'd2, 16'd374);
    send_frame(8'h01, 8'h77, 1'b0, 8'd1, 16'd375);
    send_frame(8'h01, 8'hC2, 1'b0, 8'd1, 16'd450);
    send_frame(8'h01, 8'hC3, 1'b1, 8'd0, 16'd0);
    expect_held("range451", 8'd1, 16'd450);
    send_frame(8'h01, 8'h5E, 1'b0, 8'd2, 16'd350, 1'b1);
    expect_held("clr_at_eval", 8'd2, 16'd350);
    send_frame(8'h01, 8'hAA, 1'b0, 8'd1, 16'd426);
    send_byte(8'hAA);
    send_byte(8'h01);
    exp_q.push_back('{1'b1, 8'd0, 16'd0, cyc + TC});
    check("busy_partial", 32'(bus.busy), 32'd1);
    repeat (TC + 3) @(negedge clk);
    check("busy_after_timeout", 32'(bus.busy), 32'd0);
    expect_held("timeout", 8'd1, 16'd426);
    send_frame(8'h01, 8'h7C, 1'b0, 8'd1, 16'd380);
    send_byte(8'hAA);
    send_byte(8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_verdict", 32'(bus.verdict), 32'd0);
    check("midrst_temp", 32'(bus.temp_tenths), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_vv", 32'(bus.verdict_valid), 32'd0);
    check("midrst_err", 32'(bus.frame_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check("busy_after_55", 32'(bus.busy), 32'd0);
    send_frame(8'h01, 8'h5E, 1'b0, 8'd2, 16'd350);
    expect_held("post_reset", 8'd2, 16'd350);
    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
